decimator_avg: RTL and testbench

DECIMATOR_AVG -- requirements
Module: decimator_avg

---
 rtl/decimator_avg.sv | 138 +++++++++++++
 tb/tb_decimator_avg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decimator_avg.sv
// Decimating stage between the low-pass filter and the downstream consumer.
// Groups of N = 2**DECIM_LOG2 accepted samples produce one output sample.
// With DECIM_AVG_EN defined the output is the floor average of the group;
// otherwise it is the first sample of each group (plain decimation).
// Synchronous active-low reset on aresetn, single clock aclk.

module decimator_avg #(
    parameter int DECIM_LOG2 = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_data_tdata,
    input  logic        s_axis_data_tvalid,
    output logic        s_axis_data_tready,
    output logic [31:0] m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready
);

    localparam int AW = 32 + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] LAST_PHASE = '1;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [DECIM_LOG2-1:0]  count_q, count_d;
    logic [31:0]            tdata_q, tdata_d;
    logic                   inXfer;
    logic                   outXfer;
    logic                   finalXfer;
    logic [31:0]            result;

    assign m_axis_data_tvalid = (state_q == HOLD);
    assign s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready;
    assign m_axis_data_tdata  = tdata_q;

    assign inXfer    = s_axis_data_tvalid && s_axis_data_tready;
    assign outXfer   = m_axis_data_tvalid && m_axis_data_tready;
    assign finalXfer = inXfer && (count_q == LAST_PHASE);

`ifdef DECIM_AVG_EN
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sampleExt;
    logic signed [AW-1:0] sum;

    assign sampleExt = {{DECIM_LOG2{s_axis_data_tdata[31]}}, s_axis_data_tdata};
    assign sum       = acc_q + sampleExt;
    // Dropping the low DECIM_LOG2 bits of the full sum is the floor average.
    assign result    = sum[AW-1:DECIM_LOG2];

    // Accumulator: restart on phase 0, otherwise add the sign-extended sample
    always_comb begin
        acc_d = acc_q;
        if (inXfer) begin
            if (count_q == '0) begin
                acc_d = sampleExt;
            end else begin
                acc_d = sum;
            end
        end
    end

    // Accumulator register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic [31:0] first_q, first_d;

    assign result = first_q;

    // Capture the first sample of each group; it becomes the group result
    always_comb begin
        first_d = first_q;
        if (inXfer && (count_q == '0)) begin
            first_d = s_axis_data_tdata;
        end
    end

    // First-sample register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            first_q <= '0;
        end else begin
            first_q <= first_d;
        end
    end
`endif

    // Next state, phase counter and output data selection
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tdata_d = tdata_q;
        if (inXfer) begin
            count_d = count_q + 1'b1;
        end
        if (finalXfer) begin
            tdata_d = result;
        end
        case (state_q)
            ACCUM: begin
                if (finalXfer) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (finalXfer) begin
                    state_d = HOLD;
                end else if (outXfer) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ACCUM;
            count_q <= '0;
            tdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tdata_q <= tdata_d;
        end
    end

endmodule

// File: tb/tb_decimator_avg.sv
// Self-checking bench for decimator_avg (N = 4). Works for both builds:
// expected values follow DECIM_AVG_EN when it is defined.

module tb_decimator_avg;

    localparam int L = 2;
    localparam int N = 1 << L;

`ifdef DECIM_AVG_EN
    localparam logic [31:0] A1 = 32'd25;
    localparam logic [31:0] A2 = 32'hFFFF_FFFE;
    localparam logic [31:0] A3 = 32'd8;
    localparam logic [31:0] A4 = 32'd12;
    localparam logic [31:0] HA = 32'd2;
`else
    localparam logic [31:0] A1 = 32'd10;
    localparam logic [31:0] A2 = 32'hFFFF_FFFF;
    localparam logic [31:0] A3 = 32'd7;
    localparam logic [31:0] A4 = 32'd11;
    localparam logic [31:0] HA = 32'd1;
`endif
    localparam logic [31:0] MAXP = 32'h7FFF_FFFF;

    typedef struct {
        logic        rstn;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] sData = '0;
    logic        sValid = 1'b0;
    logic        sReady;
    logic [31:0] mData;
    logic        mValid;
    logic        mReady = 1'b0;

    int          compared = 0;
    int          mismatched = 0;

    bit          expValid = 1'b0;
    logic [31:0] expData = '0;
    int          grp[$];
    logic        lastSready = 1'b0;
    vec_t        vecs[$];

    always #5 aclk = ~aclk;

    decimator_avg #(.DECIM_LOG2(L)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_data_tdata (sData),
        .s_axis_data_tvalid(sValid),
        .s_axis_data_tready(sReady),
        .m_axis_data_tdata (mData),
        .m_axis_data_tvalid(mValid),
        .m_axis_data_tready(mReady)
    );

    function automatic logic [31:0] groupResult();
`ifdef DECIM_AVG_EN
        longint sum = 0;
        foreach (grp[i]) sum += longint'(grp[i]);
        return 32'(sum >>> L);
`else
        return 32'(grp[0]);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the reference model, check the DUT
    task automatic applyStimulus(input logic rstn, input logic sv,
                                 input logic [31:0] sd, input logic mr);
        bit sr;
        @(negedge aclk);
        aresetn = rstn;
        sValid  = sv;
        sData   = sd;
        mReady  = mr;
        #1;
        sr = !expValid || mr;
        lastSready = sReady;
        checkOutput("s_tready", {31'b0, sReady}, {31'b0, sr});
        if (!rstn) begin
            expValid = 1'b0;
            expData  = '0;
            grp.delete();
        end else begin
            if (expValid && mr) expValid = 1'b0;
            if (sv && sr) begin
                grp.push_back(int'(sd));
                if (grp.size() == N) begin
                    expData  = groupResult();
                    expValid = 1'b1;
                    grp.delete();
                end
            end
        end
        @(posedge aclk);
        #1;
        checkOutput("m_tvalid", {31'b0, mValid}, {31'b0, expValid});
        checkOutput("m_tdata", mData, expData);
    endtask

    task automatic addVec(input logic rstn, input logic sv, input logic [31:0] sd,
                          input logic mr, input logic ev, input logic [31:0] ed);
        vec_t v;
        v.rstn = rstn; v.sv = sv; v.sd = sd; v.mr = mr; v.ev = ev; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // Directed table: reset, basic groups, gap, negative floor, max values
        addVec(0, 1, 32'd123,     1, 0, 32'd0);
        addVec(1, 1, 32'd10,      1, 0, 32'd0);
        addVec(1, 1, 32'd20,      1, 0, 32'd0);
        addVec(1, 0, 32'd99,      1, 0, 32'd0);
        addVec(1, 1, 32'd30,      1, 0, 32'd0);
        addVec(1, 1, 32'd40,      1, 1, A1);
        addVec(1, 0, 32'd55,      1, 0, A1);
        addVec(1, 1, 32'hFFFF_FFFF, 1, 0, A1);
        addVec(1, 1, 32'hFFFF_FFFE, 1, 0, A1);
        addVec(1, 1, 32'hFFFF_FFFE, 1, 0, A1);
        addVec(1, 1, 32'hFFFF_FFFE, 1, 1, A2);
        addVec(1, 1, 32'd7,       1, 0, A2);
        addVec(1, 1, 32'd8,       1, 0, A2);
        addVec(1, 1, 32'd9,       1, 0, A2);
        addVec(1, 1, 32'd10,      1, 1, A3);
        addVec(1, 1, 32'd11,      1, 0, A3);
        addVec(1, 1, 32'd12,      1, 0, A3);
        addVec(1, 1, 32'd13,      1, 0, A3);
        addVec(1, 1, 32'd14,      1, 1, A4);
        addVec(1, 1, MAXP,        1, 0, A4);
        addVec(1, 1, MAXP,        1, 0, A4);
        addVec(1, 1, MAXP,        1, 0, A4);
        addVec(1, 1, MAXP,        1, 1, MAXP);
        addVec(1, 0, 32'd0,       1, 0, MAXP);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstn, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            checkOutput($sformatf("vec%0d tvalid", i), {31'b0, mValid}, {31'b0, vecs[i].ev});
            checkOutput($sformatf("vec%0d tdata", i), mData, vecs[i].ed);
        end

        // Backpressure: output held stable and input stalled while m_tready=0
        for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 32'(i), 1);
        checkOutput("bp first tvalid", {31'b0, mValid}, 32'd1);
        checkOutput("bp first tdata", mData, HA);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 32'(50 + i), 0);
            checkOutput("bp s_tready", {31'b0, lastSready}, 32'd0);
            checkOutput("bp hold tvalid", {31'b0, mValid}, 32'd1);
            checkOutput("bp hold tdata", mData, HA);
        end
        applyStimulus(1, 1, 32'd8, 1);
        checkOutput("bp release s_tready", {31'b0, lastSready}, 32'd1);
        checkOutput("bp release tvalid", {31'b0, mValid}, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'd8, 1);
        checkOutput("bp next tvalid", {31'b0, mValid}, 32'd1);
        checkOutput("bp next tdata", mData, 32'd8);

        // Reset mid-group discards the partial group
        applyStimulus(1, 1, 32'd100, 1);
        applyStimulus(1, 1, 32'd200, 1);
        applyStimulus(0, 1, 32'd300, 1);
        checkOutput("rst tvalid", {31'b0, mValid}, 32'd0);
        checkOutput("rst tdata", mData, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'd4, 1);
        checkOutput("rst partial tvalid", {31'b0, mValid}, 32'd0);
        applyStimulus(1, 1, 32'd4, 1);
        checkOutput("rst group tvalid", {31'b0, mValid}, 32'd1);
        checkOutput("rst group tdata", mData, 32'd4);

        // Reset while holding a pending output drops it
        applyStimulus(1, 0, 32'd0, 0);
        applyStimulus(0, 0, 32'd0, 0);
        checkOutput("rst hold tvalid", {31'b0, mValid}, 32'd0);
        checkOutput("rst hold tdata", mData, 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0: d = 32'(int'($urandom_range(0, 200)) - 100);
                1: d = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: d = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 9) < 7),
                          d,
                          ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
